// File: rtl/pe_result_drain.sv
// Read-out unit for one PE row: snapshots all accumulators on start, pulses a
// row clear, then streams the captured words over a valid/ready port.
module pe_result_drain #(
  parameter int data_size = 8,
  parameter int num_pe    = 4,
  parameter int idx_width = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [num_pe*(2*data_size+1)-1:0]   acc_in,
  output logic                                pe_clear,
  output logic                                busy,
  output logic [2*data_size:0]                out_data,
  output logic [idx_width-1:0]                out_idx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                done
);

  // state | meaning
  // IDLE  | waiting for start; start captures the row and pulses pe_clear
  // SEND  | presenting r_snap[r_idx]; advances on each accepted word
  // DONE  | one-cycle done pulse, then back to IDLE

  localparam int                   ACC_W    = 2*data_size+1;
  localparam logic [idx_width-1:0] LAST_IDX = idx_width'(num_pe-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [ACC_W-1:0]     r_snap [num_pe];
  logic [idx_width-1:0] r_idx;
  logic [idx_width-1:0] w_next_idx;
  logic                 r_pe_clear;
  logic                 w_capture;
  logic                 w_at_last;
  logic                 w_sending;
  logic [ACC_W-1:0]     w_sel;

  assign w_at_last = (r_idx == LAST_IDX);
  assign w_sending = (r_state == SEND);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_next_idx   = '0;
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (w_at_last) begin
            w_next_state = DONE;
          end else begin
            w_next_idx = r_idx + idx_width'(1);
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Snapshot isolates the stream from later accumulator activity in the row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < num_pe; k++) begin
        r_snap[k] <= '0;
      end
    end else if (w_capture) begin
      for (int k = 0; k < num_pe; k++) begin
        r_snap[k] <= acc_in[k*ACC_W +: ACC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx      <= '0;
      r_pe_clear <= 1'b0;
    end else begin
      r_idx      <= w_next_idx;
      r_pe_clear <= w_capture;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < num_pe; k++) begin
      if (r_idx == idx_width'(k)) begin
        w_sel = r_snap[k];
      end
    end
  end

  assign pe_clear  = r_pe_clear;
  assign out_valid = w_sending;
  assign out_data  = w_sending ? w_sel : '0;
  assign out_idx   = w_sending ? r_idx : '0;
  assign out_last  = w_sending & w_at_last;
  assign done      = (r_state == DONE);
  assign busy      = (r_state == SEND) | (r_state == DONE);

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: scoreboard of expected words for a 4-PE row plus
// a directed check of a 1-PE configuration.
module tb_pe_result_drain;

  localparam int AW = 17;

  typedef struct {
    logic [AW-1:0] data;
    logic [1:0]    idx;
    logic          last;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [4*AW-1:0] acc_in = '0;
  logic            pe_clear, busy, out_valid, out_last, done;
  logic            out_ready = 1'b0;
  logic [AW-1:0]   out_data;
  logic [1:0]      out_idx;

  logic            start1 = 1'b0;
  logic [AW-1:0]   acc1 = '0;
  logic            pe_clear1, busy1, out_valid1, out_last1, done1;
  logic            out_ready1 = 1'b1;
  logic [AW-1:0]   out_data1;
  logic [0:0]      out_idx1;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   clr_cnt = 0;
  int   done_cnt = 0;
  int   xfer_cnt = 0;
  int   done_base = 0;
  logic exp_done = 1'b0;

  pe_result_drain #(.data_size(8), .num_pe(4), .idx_width(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .acc_in(acc_in),
    .pe_clear(pe_clear), .busy(busy), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  pe_result_drain #(.data_size(8), .num_pe(1), .idx_width(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .acc_in(acc1),
    .pe_clear(pe_clear1), .busy(busy1), .out_data(out_data1), .out_idx(out_idx1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mid-cycle monitor: the head of the queue must be on the port whenever
  // valid is high; it is retired when ready is also high.
  always @(negedge clk) begin
    if (reset) begin
      chk("done_timing", {31'd0, done}, {31'd0, exp_done});
      exp_done = 1'b0;
      if (pe_clear) clr_cnt++;
      if (done) done_cnt++;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_word", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("word_data", {15'd0, out_data}, {15'd0, q[0].data});
          chk("word_idx", {30'd0, out_idx}, {30'd0, q[0].idx});
          chk("word_last", {31'd0, out_last}, {31'd0, q[0].last});
          if (out_ready) begin
            exp_done = q[0].last;
            void'(q.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

  task automatic start_drain(input logic [4*AW-1:0] d);
    exp_t e;
    acc_in = d;
    start  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.data = d[k*AW +: AW];
      e.idx  = 2'(k);
      e.last = (k == 3);
      q.push_back(e);
    end
    done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    chk("clear_pulse", {31'd0, pe_clear}, 32'd1);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("busy_send", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) @(posedge clk);
    #1;
    chk("done_count", done_cnt - done_base, 32'd1);
    chk("queue_drained", q.size(), 32'd0);
  endtask

  logic [4*AW-1:0] d1, d2, d3;
  logic [7:0]      pat;
  int              c0, x0;

  initial begin
    d1  = {17'h00064, 17'h1FC02, 17'h00000, 17'h00FFF};
    d2  = {17'h12345, 17'h0A5A5, 17'h15A5A, 17'h00001};
    d3  = {17'h1ABCD, 17'h00777, 17'h10001, 17'h0F0F0};
    pat = 8'b10110100;

    #1;
    chk("rst_clear", {31'd0, pe_clear}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {15'd0, out_data}, 32'd0);
    chk("rst_idx", {30'd0, out_idx}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst1_valid", {31'd0, out_valid1}, 32'd0);
    #21 reset = 1'b1;
    @(posedge clk); #1;

    // basic drain
    out_ready = 1'b1;
    c0 = clr_cnt;
    start_drain(d1);
    @(posedge clk); #1;
    chk("clear_one_cycle", {31'd0, pe_clear}, 32'd0);
    wait_done(20);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("basic_clears", clr_cnt - c0, 32'd1);

    // backpressure
    out_ready = 1'b0;
    x0 = xfer_cnt;
    start_drain(d1);
    for (int i = 0; i < 8; i++) begin
      out_ready = pat[i];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(20);
    chk("bp_transfers", xfer_cnt - x0, 32'd4);

    // snapshot isolation
    start_drain(d2);
    acc_in = {4{17'h1FFFF}};
    wait_done(20);

    // start while busy and on the done cycle
    c0 = clr_cnt;
    start_drain(d1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("no_restart_idx", {30'd0, out_idx}, 32'd2);
    chk("no_extra_clear", {31'd0, pe_clear}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_cycle", {31'd0, done}, 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    chk("done_start_ignored", {31'd0, out_valid}, 32'd0);
    chk("done_start_noclear", {31'd0, pe_clear}, 32'd0);
    start = 1'b0;
    start_drain(d3);
    wait_done(20);
    chk("busy_clears", clr_cnt - c0, 32'd2);

    // asynchronous reset mid-transfer
    start_drain(d1);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", {15'd0, out_data}, 32'd0);
    chk("mid_rst_idx", {30'd0, out_idx}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_done", done_cnt - done_base, 32'd0);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    start_drain(d2);
    wait_done(20);

    // single-PE configuration
    acc1   = 17'h0ABCD;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    acc1   = 17'h00000;
    chk("pe1_clear", {31'd0, pe_clear1}, 32'd1);
    chk("pe1_valid", {31'd0, out_valid1}, 32'd1);
    chk("pe1_data", {15'd0, out_data1}, 32'h0ABCD);
    chk("pe1_idx", {31'd0, out_idx1}, 32'd0);
    chk("pe1_last", {31'd0, out_last1}, 32'd1);
    @(posedge clk); #1;
    chk("pe1_done", {31'd0, done1}, 32'd1);
    chk("pe1_valid_drop", {31'd0, out_valid1}, 32'd0);
    chk("pe1_busy_done", {31'd0, busy1}, 32'd1);
    @(posedge clk); #1;
    chk("pe1_done_pulse", {31'd0, done1}, 32'd0);
    chk("pe1_idle", {31'd0, busy1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Read-out unit for one row of LUT-multiply-accumulate PEs in the systolic array.
- On a start command it snapshots the accumulators (out_c) of num_pe PEs and issues a one-cycle clear to the row.
- It then streams the captured results one per handshake over a valid/ready interface to the result buffer or host.
- It sits between the PE row outputs and the downstream result collector.

Parameters:
- data_size, 8, PE operand width; accumulator width is derived as 2*data_size+1.
- num_pe, 4, number of PEs in the drained row (>=1).
- idx_width, 2, width of out_idx; 2**idx_width >= num_pe is required.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  drain request; sampled only in IDLE.
- acc_in  input  num_pe*(2*data_size+1)  flattened PE accumulators; PE k occupies bits [k*(2*data_size+1) +: 2*data_size+1].
- pe_clear  output  1  one-cycle pulse to zero the PE row accumulators.
- busy  output  1  high in SEND and DONE.
- out_data  output  2*data_size+1  current result word.
- out_idx  output  idx_width  PE index of out_data.
- out_valid  output  1  out_data/out_idx/out_last valid.
- out_ready  input  1  downstream accept.
- out_last  output  1  marks the word from PE num_pe-1.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE; snapshot registers=0; index counter=0.
  - All outputs 0: pe_clear, busy, out_data, out_idx, out_valid, out_last, done.
  - Reset mid-transfer abandons the transfer; no done pulse is generated.
- States: IDLE, SEND, DONE. All outputs are registered or decoded from registered state and snapshot only; no combinational path from out_ready or start to any output.
- IDLE:
  - start=1 at edge t: snapshot[k] <= acc_in slice k for all k; idx <= 0; state <= SEND.
  - pe_clear is high for exactly the cycle after edge t.
  - First out_valid is high in that same cycle. Latency from start to first valid word is 1 cycle.
- SEND:
  - out_valid=1; out_data=snapshot[idx]; out_idx=idx; out_last=(idx==num_pe-1).
  - Transfer occurs on an edge where out_valid & out_ready.
  - On a transfer with idx<num_pe-1: idx <= idx+1.
  - On a transfer with idx==num_pe-1: state <= DONE, out_valid drops.
  - With out_ready=0, out_data, out_idx and out_last hold stable and out_valid stays high.
  - Back-to-back transfers with out_ready held high give 1 word per cycle.
- DONE: done=1 for one cycle; busy=1; state <= IDLE unconditionally.
- start while busy (SEND/DONE) is ignored. No queueing; the next start is honoured only when sampled in IDLE.
- start asserted in the same cycle as the done pulse is ignored. start held high continuously re-triggers on the first IDLE cycle.
- acc_in changes after the capture edge do not affect the words being streamed; the snapshot is isolated.
- num_pe=1: one word with out_last=1 on it.
- Widths:
  - The snapshot is an unsigned copy; no arithmetic is performed.
  - out_idx is zero-extended from the counter.
  - Unused upper out_idx values never appear.
- busy is high from the cycle after capture until the DONE cycle inclusive; it is low in IDLE.

Test Plan:
1. Basic drain (num_pe=4):
   - Stimulus: acc_in = {17'h00064, 17'h1FC02, 17'h00000, 17'h00FFF} for PE3..PE0, start pulse, out_ready=1.
   - Response: pe_clear high for 1 cycle.
   - Words 0x00FFF, 0x00000, 0x1FC02, 0x00064 with idx 0..3 on 4 consecutive cycles; out_last only on idx 3; done 1 cycle later.
2. Backpressure:
   - Stimulus: same data; out_ready toggles 0,0,1,0,1,1,0,1.
   - Response: each word holds stable while not ready; exactly 4 transfers in order; done after the 4th accept.
3. Snapshot isolation:
   - Stimulus: change acc_in to all 17'h1FFFF one cycle after start.
   - Response: streamed words equal the pre-start values, not 0x1FFFF.
4. Start while busy:
   - Stimulus: pulse start during SEND and again on the done cycle.
   - Response: no extra pe_clear, no restart, exactly 4 words; a start in the following IDLE cycle triggers a new drain.
5. Reset mid-operation:
   - Stimulus: assert reset=0 asynchronously (between clock edges) after 2 words transferred.
   - Response: all outputs 0 immediately, no done.
   - After release, IDLE; a new start streams a fresh snapshot from idx 0.
6. Single-PE configuration:
   - Stimulus: num_pe=1, acc_in=17'h0ABCD, start, out_ready=1.
   - Response: one word 0x0ABCD, idx 0, out_last=1, done on the next cycle.
